// File: rtl/sfm_int_slicer_if.sv
// sfm_int_slicer_if: valid/ready stream carrying packed words with a byte strobe.
interface sfm_int_slicer_if #(
    parameter int unsigned DATA_WIDTH = 160
) ();
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, data, strb, input ready);
    modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/sfm_int_slicer.sv
// sfm_int_slicer: re-emits each packed integer word as R low-aligned slices so the cast stage sees every lane.
module sfm_int_slicer #(
    parameter int unsigned DATA_WIDTH = 160,
    parameter int unsigned INT_WIDTH  = 8,
    parameter logic [2:0]  FPFORMAT   = 3'd2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic             busy_o,
    sfm_int_slicer_if.slave  stream_i,
    sfm_int_slicer_if.master stream_o
);
    // Float format encoding: 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT.
    function automatic int unsigned fp_width(input logic [2:0] f);
        return f == 3'd0 ? 32 : f == 3'd1 ? 64 : f == 3'd3 ? 8 : 16;
    endfunction

    localparam int unsigned FP_WIDTH  = fp_width(FPFORMAT);
    localparam int unsigned ACTUAL_DW = DATA_WIDTH - 32;
    localparam int unsigned R         = INT_WIDTH < FP_WIDTH ? FP_WIDTH / INT_WIDTH : 1;
    localparam int unsigned S         = ACTUAL_DW / R;
    localparam int unsigned SB        = S / 8;
    localparam int unsigned CW        = $clog2(R) + 1;
    localparam int unsigned SW        = DATA_WIDTH / 8;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                 state_q;
    logic [ACTUAL_DW-1:0]   buf_data_q;
    logic [ACTUAL_DW/8-1:0] buf_strb_q;
    logic [CW-1:0]          cnt_q, last_q, last_d;
    logic                   idle, bypass, at_last, in_hs, out_hs;

    // Trailing all-zero slices are never emitted; interior ones still are.
    always_comb begin
        last_d = '0;
        for (int k = 0; k < int'(R); k++)
            if (|stream_i.strb[k*SB +: SB]) last_d = CW'(k);
    end

    assign idle    = state_q == IDLE;
    assign bypass  = idle && !enable_i;
    assign at_last = cnt_q == last_q;
    assign busy_o  = !idle;
    assign in_hs   = stream_i.valid && stream_i.ready && !bypass;
    assign out_hs  = stream_o.ready && !idle;

    assign stream_i.ready = bypass ? stream_o.ready : idle || (stream_o.ready && at_last);
    assign stream_o.valid = bypass ? stream_i.valid : !idle;
    assign stream_o.data  = bypass ? stream_i.data : DATA_WIDTH'(buf_data_q[cnt_q*S +: S]);
    assign stream_o.strb  = bypass ? stream_i.strb : SW'(buf_strb_q[cnt_q*SB +: SB]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            buf_data_q <= '0;
            buf_strb_q <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            buf_data_q <= '0;
            buf_strb_q <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
        end else if (in_hs) begin
            buf_data_q <= stream_i.data[ACTUAL_DW-1:0];
            buf_strb_q <= stream_i.strb[ACTUAL_DW/8-1:0];
            cnt_q      <= '0;
            last_q     <= last_d;
            state_q    <= |stream_i.strb[ACTUAL_DW/8-1:0] ? EMIT : IDLE;
        end else if (out_hs) begin
            cnt_q      <= at_last ? '0 : cnt_q + 1'b1;
            state_q    <= at_last ? IDLE : EMIT;
        end
    end
endmodule

// File: tb/tb_sfm_int_slicer.sv
// tb_sfm_int_slicer: directed checks of slicing, bypass, backpressure and reset/clear for R=2, S=64.
module tb_sfm_int_slicer;
    logic clk = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, enable_i = 1'b1;
    logic busy_o;
    int   n_cmp = 0, n_err = 0;

    localparam logic [63:0]  A  = 64'h0706050403020100;
    localparam logic [63:0]  B  = 64'h0F0E0D0C0B0A0908;
    localparam logic [159:0] BP = {32'hCAFEF00D, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321};

    sfm_int_slicer_if #(.DATA_WIDTH(160)) in_if ();
    sfm_int_slicer_if #(.DATA_WIDTH(160)) out_if ();

    sfm_int_slicer #(.DATA_WIDTH(160), .INT_WIDTH(8), .FPFORMAT(3'd2)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .busy_o(busy_o), .stream_i(in_if), .stream_o(out_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [159:0] d, input logic [19:0] s);
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.strb  = s;
        step();
        in_if.valid = 1'b0;
    endtask

    function automatic logic [63:0] w(input logic [63:0] base, input int i);
        return base + 64'(i);
    endfunction

    task automatic test_reset();
        in_if.valid = 1'b0; in_if.data = '0; in_if.strb = '0; out_if.ready = 1'b1;
        #3;
        n_cmp++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_if.valid); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        step(); step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_basic();
        in_if.valid = 1'b1; in_if.data = {32'hDEADBEEF, B, A}; in_if.strb = 20'hFFFFF;
        #1;
        n_cmp++; if (in_if.ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready: got %b want 1", in_if.ready); end
        n_cmp++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL basic_idle_valid: got %b want 0", out_if.valid); end
        step();
        in_if.valid = 1'b0;
        #1;
        n_cmp++; if (out_if.data !== {96'b0, A}) begin n_err++; $display("FAIL basic_beat0_data: got %h want %h", out_if.data, {96'b0, A}); end
        n_cmp++; if (out_if.strb !== 20'h000FF) begin n_err++; $display("FAIL basic_beat0_strb: got %h want 000ff", out_if.strb); end
        n_cmp++; if ({out_if.valid, busy_o, in_if.ready} !== 3'b110) begin n_err++; $display("FAIL basic_beat0_ctl: got %b want 110", {out_if.valid, busy_o, in_if.ready}); end
        step();
        n_cmp++; if (out_if.data !== {96'b0, B}) begin n_err++; $display("FAIL basic_beat1_data: got %h want %h", out_if.data, {96'b0, B}); end
        n_cmp++; if (out_if.strb !== 20'h000FF) begin n_err++; $display("FAIL basic_beat1_strb: got %h want 000ff", out_if.strb); end
        n_cmp++; if ({out_if.valid, in_if.ready} !== 2'b11) begin n_err++; $display("FAIL basic_beat1_ctl: got %b want 11", {out_if.valid, in_if.ready}); end
        step();
        n_cmp++; if ({out_if.valid, busy_o} !== 2'b00) begin n_err++; $display("FAIL basic_idle_after: got %b want 00", {out_if.valid, busy_o}); end
    endtask

    task automatic test_partial();
        push({32'h0, B, A}, 20'h000FF);
        n_cmp++; if ({out_if.valid, in_if.ready, out_if.data, out_if.strb} !== {2'b11, 96'b0, A, 20'h000FF}) begin
            n_err++; $display("FAIL partial_low: got v=%b r=%b d=%h s=%h want v=1 r=1 d=%h s=000ff", out_if.valid, in_if.ready, out_if.data, out_if.strb, A); end
        step();
        n_cmp++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL partial_low_end: got %b want 0", out_if.valid); end
        push({32'h0, B, A}, 20'h0FF00);
        n_cmp++; if ({out_if.valid, out_if.data, out_if.strb} !== {1'b1, 96'b0, A, 20'h0}) begin
            n_err++; $display("FAIL partial_interior: got v=%b d=%h s=%h want v=1 d=%h s=00000", out_if.valid, out_if.data, out_if.strb, A); end
        step();
        n_cmp++; if ({out_if.valid, out_if.data, out_if.strb} !== {1'b1, 96'b0, B, 20'h000FF}) begin
            n_err++; $display("FAIL partial_high: got v=%b d=%h s=%h want v=1 d=%h s=000ff", out_if.valid, out_if.data, out_if.strb, B); end
        step();
        push({32'h0, B, A}, 20'h00000);
        n_cmp++; if ({out_if.valid, busy_o} !== 2'b00) begin n_err++; $display("FAIL zero_strb: got %b want 00", {out_if.valid, busy_o}); end
        push({32'hFFFFFFFF, B, A}, 20'hF0000);
        n_cmp++; if ({out_if.valid, busy_o} !== 2'b00) begin n_err++; $display("FAIL header_strb_only: got %b want 00", {out_if.valid, busy_o}); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] base = 64'h1111000000000000;
        int idx = 0, beat = 0, first = -1, lastc = -1;
        logic acc;
        in_if.valid = 1'b1; in_if.data = {32'h0, w(base, 1), w(base, 0)}; in_if.strb = 20'h0FFFF;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_if.valid) begin
                n_cmp++;
                if (beat >= 8) begin n_err++; $display("FAIL b2b_extra: beat %0d got %h want none", beat, out_if.data); end
                else if (out_if.data !== {96'b0, w(base, beat)}) begin n_err++; $display("FAIL b2b_beat%0d: got %h want %h", beat, out_if.data, {96'b0, w(base, beat)}); end
                if (first < 0) first = c;
                lastc = c;
                beat++;
            end
            acc = in_if.valid && in_if.ready;
            step();
            if (acc) begin
                idx++;
                if (idx < 4) in_if.data = {32'h0, w(base, 2*idx+1), w(base, 2*idx)};
                else in_if.valid = 1'b0;
            end
        end
        n_cmp++; if (beat !== 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", beat); end
        n_cmp++; if (lastc - first !== 7) begin n_err++; $display("FAIL b2b_gapless: got span %0d want 7", lastc - first); end
    endtask

    task automatic test_backpressure();
        logic [63:0] base = 64'h2222000000000000;
        logic [63:0] q[$];
        int idx = 0, got = 0, cyc = 0;
        logic acc, stalled = 1'b0;
        in_if.valid = 1'b1; in_if.data = {32'h0, w(base, 1), w(base, 0)}; in_if.strb = 20'h0FFFF;
        while ((idx < 4 || q.size() != 0) && cyc < 300) begin
            out_if.ready = 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                n_cmp++;
                if (!out_if.valid || q.size() == 0 || out_if.data !== {96'b0, q[0]} || out_if.strb !== 20'h000FF) begin
                    n_err++; $display("FAIL bp_hold: got v=%b d=%h s=%h want held beat", out_if.valid, out_if.data, out_if.strb); end
            end
            if (out_if.valid && out_if.ready) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL bp_extra: got %h want none", out_if.data); end
                else begin
                    if (out_if.data !== {96'b0, q[0]} || out_if.strb !== 20'h000FF) begin
                        n_err++; $display("FAIL bp_beat%0d: got %h/%h want %h/000ff", got, out_if.data, out_if.strb, q[0]); end
                    void'(q.pop_front());
                end
                got++;
            end
            stalled = out_if.valid && !out_if.ready;
            acc = in_if.valid && in_if.ready;
            if (acc) begin q.push_back(w(base, 2*idx)); q.push_back(w(base, 2*idx+1)); end
            step();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) in_if.data = {32'h0, w(base, 2*idx+1), w(base, 2*idx)};
                else in_if.valid = 1'b0;
            end
        end
        out_if.ready = 1'b1;
        n_cmp++; if (got !== 8) begin n_err++; $display("FAIL bp_count: got %0d beats want 8 (cycles %0d)", got, cyc); end
        step();
    endtask

    task automatic test_bypass();
        enable_i = 1'b0;
        in_if.valid = 1'b1; in_if.data = BP; in_if.strb = 20'hABCDE; out_if.ready = 1'b0;
        #1;
        n_cmp++; if ({out_if.valid, out_if.data, out_if.strb} !== {1'b1, BP, 20'hABCDE}) begin
            n_err++; $display("FAIL bypass_fwd: got v=%b d=%h s=%h want v=1 d=%h s=abcde", out_if.valid, out_if.data, out_if.strb, BP); end
        n_cmp++; if (in_if.ready !== 1'b0) begin n_err++; $display("FAIL bypass_ready0: got %b want 0", in_if.ready); end
        out_if.ready = 1'b1;
        #1;
        n_cmp++; if (in_if.ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready1: got %b want 1", in_if.ready); end
        step();
        n_cmp++; if ({busy_o, out_if.data} !== {1'b0, BP}) begin n_err++; $display("FAIL bypass_nostate: got busy=%b d=%h want busy=0", busy_o, out_if.data); end
        in_if.valid = 1'b0;
        #1;
        n_cmp++; if (out_if.valid !== 1'b0) begin n_err++; $display("FAIL bypass_idle: got %b want 0", out_if.valid); end
        enable_i = 1'b1;
        step();
    endtask

    task automatic test_enable_mid();
        push({32'h0, B, A}, 20'h0FFFF);
        enable_i = 1'b0;
        #1;
        n_cmp++; if ({out_if.valid, out_if.data} !== {1'b1, 96'b0, A}) begin n_err++; $display("FAIL enmid_beat0: got %h want %h", out_if.data, {96'b0, A}); end
        step();
        n_cmp++; if ({busy_o, out_if.data} !== {1'b1, 96'b0, B}) begin n_err++; $display("FAIL enmid_beat1: got busy=%b d=%h want busy=1 d=%h", busy_o, out_if.data, B); end
        step();
        in_if.valid = 1'b1; in_if.data = BP; in_if.strb = 20'hABCDE;
        #1;
        n_cmp++; if ({out_if.valid, out_if.data} !== {1'b1, BP}) begin n_err++; $display("FAIL enmid_bypass: got %h want %h", out_if.data, BP); end
        in_if.valid = 1'b0;
        enable_i = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        push({32'h0, 64'hDDDD, 64'hCCCC}, 20'h0FFFF);
        step();
        n_cmp++; if (out_if.data !== 160'hDDDD) begin n_err++; $display("FAIL rstmid_cnt1: got %h want dddd", out_if.data); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if ({out_if.valid, busy_o} !== 2'b00) begin n_err++; $display("FAIL rstmid_async: got %b want 00", {out_if.valid, busy_o}); end
        step();
        rst_ni = 1'b1;
        push({32'h0, 64'hFFFF, 64'hEEEE}, 20'h0FFFF);
        n_cmp++; if ({out_if.valid, out_if.data} !== {1'b1, 160'hEEEE}) begin n_err++; $display("FAIL rstmid_restart: got %h want eeee", out_if.data); end
        step(); step();
        push({32'h0, 64'h5555, 64'h4444}, 20'h0FFFF);
        step();
        out_if.ready = 1'b0;
        clear_i = 1'b1;
        #1;
        n_cmp++; if ({out_if.valid, out_if.data} !== {1'b1, 160'h5555}) begin n_err++; $display("FAIL clrmid_pending: got v=%b d=%h want v=1 d=5555", out_if.valid, out_if.data); end
        step();
        clear_i = 1'b0;
        n_cmp++; if ({out_if.valid, busy_o} !== 2'b00) begin n_err++; $display("FAIL clrmid_cleared: got %b want 00", {out_if.valid, busy_o}); end
        out_if.ready = 1'b1;
        push({32'h0, 64'h7777, 64'h6666}, 20'h0FFFF);
        n_cmp++; if ({out_if.valid, out_if.data} !== {1'b1, 160'h6666}) begin n_err++; $display("FAIL clrmid_restart: got %h want 6666", out_if.data); end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_back_to_back();
        test_backpressure();
        test_bypass();
        test_enable_mid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
